divider_8: RTL and testbench
============================

Name: divider_8

Overview:
- Sequential unsigned 8-bit restoring divider. It is the inverse-operation companion to the lab's shift-add multiplier.
- The divisor is loaded from SW with Load_Divisor. The dividend is taken from SW when Run starts an operation.
- The block produces quotient and remainder over 8 shift/subtract iterations.
- It drives the same six-digit hex display arrangement through the existing HexDriver.

Parameters:
- N, 8, operand/quotient/remainder width. The display mapping assumes 8.
- ITERS, N, number of shift/subtract iterations.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-low; clears all state.
- Load_Divisor  input  1  active-high; in IDLE, latches SW into the divisor register.
- Run  input  1  active-high level; in IDLE, starts a divide using SW as the dividend.
- SW  input  N  operand switches.
- Qval  output  N  quotient register.
- Rval  output  N  remainder, low N bits of the internal remainder register.
- Busy  output  1  high in SHIFT and SUB.
- Done  output  1  high in DONE.
- Div_Zero  output  1  set when the divisor was 0 at start.
- Shift  output  1  high in SHIFT state; debug.
- Sub  output  1  high in SUB state; debug.
- HEX0..HEX5  output  7 each  SW[3:0], SW[7:4], Qval[3:0], Qval[7:4], Rval[3:0], Rval[7:4].

Behaviour:
- Reset low, taking effect immediately and independent of Clk:
  - state=IDLE, iteration counter=0.
  - Divisor D=0, Q=0, internal R (N+1 bits)=0.
  - Busy=Done=Div_Zero=Shift=Sub=0.
  - Reset mid-operation aborts; no partial result is retained.
- States: IDLE, SHIFT, SUB, DONE. Edge numbering below starts at edge 1, the edge that samples Run=1 in IDLE.
- IDLE:
  - Load_Divisor=1: D<=SW, Q<=0, R<=0, Div_Zero<=0; stay IDLE. Load_Divisor takes priority over Run on the same edge, so Run still high next edge starts with the new D.
  - Load_Divisor=0 and Run=1, D!=0: Q<=SW, R<=0, count<=0, Div_Zero<=0; go to SHIFT.
  - Load_Divisor=0 and Run=1, D==0: Q<=8'hFF, R<=SW, Div_Zero<=1; go to DONE at edge 1.
- SHIFT: {R,Q} <= {R,Q}<<1, with Q[0]<=0; go to SUB.
- SUB:
  - trial = R - {1'b0,D}, computed at N+1 bits.
  - No borrow (R>=D): R<=trial, Q[0]<=1. Otherwise R unchanged, Q[0] stays 0.
  - count<=count+1. If count==ITERS-1, go to DONE, else go to SHIFT.
- Timing: iteration i shifts at edge 2i and subtracts at edge 2i+1. Done rises after edge 17, total latency 17 cycles.
- Result invariant at DONE: Qval*D + Rval == dividend, and Rval < D when D!=0. R[N] is 0 at DONE.
- DONE:
  - Outputs are held.
  - Go to IDLE when Run=0. While Run stays 1 there is no restart (single operation per press).
  - Load_Divisor is ignored.
- Load_Divisor and Run are ignored in SHIFT, SUB and DONE. SW changes during an operation have no effect.
- Busy, Done, Shift and Sub are decoded from registered state (Moore). Div_Zero is a register.

Decomposition:
- Package divider_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} div_state_t;
  - localparam N=8 and the counter width $clog2(N).
- One sub-module, divider_control: owns the FSM, iteration counter and Div_Zero decision. It outputs load_q, load_d, shift_en and sub_en strobes.
- The datapath (D, Q, R registers, subtractor) stays in divider_8. Hex digits reuse the existing HexDriver.

Test Plan:
- Reset, load D=7, Run with SW=200 (0xC8) -> Done after 17 edges, Qval=0x1C, Rval=0x04, Div_Zero=0; Busy high for exactly 16 cycles.
- D=1, dividend 0xFF -> Qval=0xFF, Rval=0x00. Then D=0xFF, dividend 0xFF -> Qval=0x01, Rval=0x00.
- D=9, dividend 5 -> Qval=0x00, Rval=0x05 (dividend smaller than divisor).
- D=0 (after reset), Run with SW=0x96 -> Done after edge 1, Qval=0xFF, Rval=0x96, Div_Zero=1. A subsequent Load_Divisor clears Div_Zero.
- Load_Divisor and Run asserted on the same edge with SW=0x10 -> D=0x10 and state stays IDLE. Next edge starts the divide with dividend 0x10 -> Qval=0x01, Rval=0x00.
- Start 200/7, pull Reset low between edges 8 and 9 -> all outputs 0 immediately, IDLE. Also: hold Run through DONE for 50 cycles -> Done stays 1, results unchanged; release and re-press restarts.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Includes the seven-segment decode used by the hex display driver.
package divider_pkg;

    localparam int N     = 8;
    localparam int ITERS = N;
    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/divider_control.sv
// Sequencer for the restoring divider: state, iteration count and the
// divide-by-zero flag; emits one-cycle strobes that steer the datapath.
module divider_control
    import divider_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load_divisor,
    input  logic i_run,
    input  logic i_d_zero,
    output logic o_load_d,
    output logic o_load_q,
    output logic o_zero_start,
    output logic o_shift_en,
    output logic o_sub_en,
    output logic o_busy,
    output logic o_done,
    output logic o_shift,
    output logic o_sub,
    output logic o_div_zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_div_zero;
    logic             w_div_zero_nxt;

    // State, iteration counter and divide-by-zero flag registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_div_zero <= w_div_zero_nxt;
        end
    end

    // Next-state and datapath strobe decode
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_div_zero_nxt = r_div_zero;
        o_load_d       = 1'b0;
        o_load_q       = 1'b0;
        o_zero_start   = 1'b0;
        o_shift_en     = 1'b0;
        o_sub_en       = 1'b0;
        case (r_state)
            IDLE: begin
                // Divisor load wins over Run so a held Run picks up the new D
                if (i_load_divisor) begin
                    o_load_d       = 1'b1;
                    w_div_zero_nxt = 1'b0;
                end else if (i_run) begin
                    if (i_d_zero) begin
                        o_zero_start   = 1'b1;
                        w_div_zero_nxt = 1'b1;
                        w_state_nxt    = DONE;
                    end else begin
                        o_load_q       = 1'b1;
                        w_count_nxt    = '0;
                        w_div_zero_nxt = 1'b0;
                        w_state_nxt    = SHIFT;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                o_shift_en  = 1'b1;
                w_state_nxt = SUB;
            end
            SUB: begin
                o_sub_en    = 1'b1;
                w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_count == LAST_CNT) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            DONE: begin
                if (!i_run) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_busy     = (r_state == SHIFT) || (r_state == SUB);
    assign o_done     = (r_state == DONE);
    assign o_shift    = (r_state == SHIFT);
    assign o_sub      = (r_state == SUB);
    assign o_div_zero = r_div_zero;

endmodule

// File: rtl/hexdriver.sv
// Seven-segment driver for one hex digit, shared with the multiplier lab.
module HexDriver
    import divider_pkg::*;
(
    input  logic [3:0] In0,
    output logic [6:0] Out0
);

    assign Out0 = hex_to_seg(In0);

endmodule

// File: rtl/divider_8.sv
// Sequential unsigned restoring divider: divisor loaded from SW, dividend
// taken from SW at Run, quotient/remainder shown on six hex digits.
module divider_8
    import divider_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Load_Divisor,
    input  logic         Run,
    input  logic [N-1:0] SW,
    output logic [N-1:0] Qval,
    output logic [N-1:0] Rval,
    output logic         Busy,
    output logic         Done,
    output logic         Div_Zero,
    output logic         Shift,
    output logic         Sub,
    output logic [6:0]   HEX0,
    output logic [6:0]   HEX1,
    output logic [6:0]   HEX2,
    output logic [6:0]   HEX3,
    output logic [6:0]   HEX4,
    output logic [6:0]   HEX5
);

    logic [N-1:0] r_d;
    logic [N-1:0] r_q;
    logic [N:0]   r_r;

    logic         w_load_d;
    logic         w_load_q;
    logic         w_zero_start;
    logic         w_shift_en;
    logic         w_sub_en;
    logic [N:0]   w_trial;
    logic         w_no_borrow;

    divider_control u_ctrl (
        .i_clk          (Clk),
        .i_rst_n        (Reset),
        .i_load_divisor (Load_Divisor),
        .i_run          (Run),
        .i_d_zero       (r_d == '0),
        .o_load_d       (w_load_d),
        .o_load_q       (w_load_q),
        .o_zero_start   (w_zero_start),
        .o_shift_en     (w_shift_en),
        .o_sub_en       (w_sub_en),
        .o_busy         (Busy),
        .o_done         (Done),
        .o_shift        (Shift),
        .o_sub          (Sub),
        .o_div_zero     (Div_Zero)
    );

    // R carries one extra bit so the shifted partial remainder never overflows
    assign w_trial     = r_r - {1'b0, r_d};
    assign w_no_borrow = (r_r >= {1'b0, r_d});

    // Divisor, quotient and partial-remainder registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_d <= '0;
            r_q <= '0;
            r_r <= '0;
        end else if (w_load_d) begin
            r_d <= SW;
            r_q <= '0;
            r_r <= '0;
        end else if (w_load_q) begin
            r_q <= SW;
            r_r <= '0;
        end else if (w_zero_start) begin
            r_q <= {N{1'b1}};
            r_r <= {1'b0, SW};
        end else if (w_shift_en) begin
            {r_r, r_q} <= {r_r[N-1:0], r_q, 1'b0};
        end else if (w_sub_en) begin
            if (w_no_borrow) begin
                r_r    <= w_trial;
                r_q[0] <= 1'b1;
            end else begin
                r_r <= r_r;
            end
        end else begin
            r_d <= r_d;
        end
    end

    assign Qval = r_q;
    assign Rval = r_r[N-1:0];

    HexDriver u_hex0 (.In0(SW[3:0]),   .Out0(HEX0));
    HexDriver u_hex1 (.In0(SW[7:4]),   .Out0(HEX1));
    HexDriver u_hex2 (.In0(Qval[3:0]), .Out0(HEX2));
    HexDriver u_hex3 (.In0(Qval[7:4]), .Out0(HEX3));
    HexDriver u_hex4 (.In0(Rval[3:0]), .Out0(HEX4));
    HexDriver u_hex5 (.In0(Rval[7:4]), .Out0(HEX5));

endmodule

// File: tb/tb_divider_8.sv
// Self-checking bench for divider_8: directed corner cases plus random
// divides compared against plain integer division.
module tb_divider_8;

    logic       Clk;
    logic       Reset;
    logic       Load_Divisor;
    logic       Run;
    logic [7:0] SW;
    logic [7:0] Qval;
    logic [7:0] Rval;
    logic       Busy;
    logic       Done;
    logic       Div_Zero;
    logic       Shift;
    logic       Sub;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checks_cnt;
    int fail_cnt;

    divider_8 dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Load_Divisor (Load_Divisor),
        .Run          (Run),
        .SW           (SW),
        .Qval         (Qval),
        .Rval         (Rval),
        .Busy         (Busy),
        .Done         (Done),
        .Div_Zero     (Div_Zero),
        .Shift        (Shift),
        .Sub          (Sub),
        .HEX0         (HEX0),
        .HEX1         (HEX1),
        .HEX2         (HEX2),
        .HEX3         (HEX3),
        .HEX4         (HEX4),
        .HEX5         (HEX5)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_divisor(input logic [7:0] d);
        SW           = d;
        Load_Divisor = 1'b1;
        step();
        Load_Divisor = 1'b0;
    endtask

    // Run one divide with the current divisor; optionally disturb SW and
    // Load_Divisor mid-operation, which must have no effect.
    task automatic run_div(input string tag, input logic [7:0] d, input logic [7:0] dvd,
                           input bit disturb);
        int edges;
        int busy_cycles;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
        if (d == 8'd0) begin
            exp_q = 8'hFF;
            exp_r = dvd;
        end else begin
            exp_q = dvd / d;
            exp_r = dvd % d;
        end
        SW  = dvd;
        Run = 1'b1;
        step();
        edges       = 1;
        busy_cycles = 0;
        while (!Done && edges < 40) begin
            if (Busy) busy_cycles++;
            if (disturb) begin
                SW           = 8'($urandom);
                Load_Divisor = 1'($urandom);
            end
            step();
            edges++;
        end
        Load_Divisor = 1'b0;
        check({tag, " done"},     32'(Done),     32'd1);
        check({tag, " latency"},  32'(edges),    (d == 8'd0) ? 32'd1 : 32'd17);
        check({tag, " busy"},     32'(busy_cycles), (d == 8'd0) ? 32'd0 : 32'd16);
        check({tag, " qval"},     32'(Qval),     32'(exp_q));
        check({tag, " rval"},     32'(Rval),     32'(exp_r));
        check({tag, " div_zero"}, 32'(Div_Zero), (d == 8'd0) ? 32'd1 : 32'd0);
        Run = 1'b0;
        step();
        check({tag, " idle"}, 32'(Done), 32'd0);
    endtask

    initial begin
        logic [7:0] q_hold;
        logic [7:0] r_hold;
        bit         held_ok;
        logic [7:0] rd;
        logic [7:0] rv;
        checks_cnt   = 0;
        fail_cnt     = 0;
        Reset        = 1'b0;
        Load_Divisor = 1'b0;
        Run          = 1'b0;
        SW           = 8'h00;
        #12;
        check("reset qval", 32'(Qval), 32'd0);
        check("reset flags", {27'd0, Busy, Done, Div_Zero, Shift, Sub}, 32'd0);
        check("reset hex0", 32'(HEX0), 32'h40);
        Reset = 1'b1;
        step();

        load_divisor(8'd7);
        run_div("200/7", 8'd7, 8'd200, 1'b0);
        load_divisor(8'd1);
        run_div("255/1", 8'd1, 8'hFF, 1'b0);
        load_divisor(8'hFF);
        run_div("255/255", 8'hFF, 8'hFF, 1'b0);
        load_divisor(8'd9);
        run_div("5/9", 8'd9, 8'd5, 1'b0);

        // Load and Run on the same edge: load wins, divide starts next edge
        SW           = 8'h10;
        Load_Divisor = 1'b1;
        Run          = 1'b1;
        step();
        check("ld+run stays idle", 32'(Busy), 32'd0);
        Load_Divisor = 1'b0;
        run_div("16/16", 8'h10, 8'h10, 1'b0);

        // Hold Run through DONE: no restart, results stable
        load_divisor(8'd7);
        SW  = 8'd200;
        Run = 1'b1;
        for (int i = 0; i < 17; i++) step();
        q_hold  = Qval;
        r_hold  = Rval;
        held_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            SW = 8'($urandom);
            step();
            if (!Done || Qval !== q_hold || Rval !== r_hold) held_ok = 1'b0;
        end
        check("hold done", 32'(held_ok), 32'd1);
        check("hold qval", 32'(q_hold), 32'h1C);
        Run = 1'b0;
        step();
        SW  = 8'd100;
        Run = 1'b1;
        step();
        check("re-press busy", 32'(Busy), 32'd1);
        for (int i = 0; i < 16; i++) step();
        check("re-press qval", 32'(Qval), 32'd14);
        check("re-press rval", 32'(Rval), 32'd2);
        Run = 1'b0;
        step();

        // Asynchronous reset between edges 8 and 9
        SW  = 8'd200;
        Run = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("pre-reset busy", 32'(Busy), 32'd1);
        Run   = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        check("abort outputs", {14'd0, Qval, Rval, Busy, Done}, 32'd0);
        check("abort flags", {29'd0, Div_Zero, Shift, Sub}, 32'd0);
        #3;
        Reset = 1'b1;
        step();

        // Divisor is 0 after reset
        run_div("div0", 8'd0, 8'h96, 1'b0);
        check("div0 hex4", 32'(HEX4), 32'h02);
        check("div0 hex5", 32'(HEX5), 32'h10);
        check("div0 hex2", 32'(HEX2), 32'h0E);
        check("div0 held", 32'(Div_Zero), 32'd1);
        load_divisor(8'd3);
        check("div0 cleared", 32'(Div_Zero), 32'd0);

        for (int k = 0; k < 20; k++) begin
            rd = 8'($urandom);
            rv = 8'($urandom);
            if (k % 7 == 3) rd = 8'd0;
            load_divisor(rd);
            run_div($sformatf("rnd%0d", k), rd, rv, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
